// File: rtl/ks_add_arbiter.sv
// Purpose : NREQ requesters share one 16-bit Kogge-Stone adder through a round-robin arbiter.
// Latency : a beat accepted on cycle n shows up as a registered result on cycle n+1.
// Backpr. : a held result (rsp_valid && !rsp_ready) drops all req_ready bits until it drains.
//
// Ports   : clk/rst (async, active-high); req_valid/req_ready/req_wide per requester;
//           req_x/req_y packed 16 bits per requester (requester i at [16i+15:16i]);
//           rsp_valid/rsp_ready result handshake; rsp_id owner, rsp_sum 17-bit X+Y+Cin,
//           rsp_last set on single-beat results and on the high beat of a wide op.
// Config  : define KS_ADD_ARBITER_WIDE_EN for 32-bit two-beat operations (LOCK state,
//           carry carried from low beat into high beat). Undefined: single-beat only.

module ks_add16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [16:0] s
);
  // gl[l]/pl[l]: group generate/propagate after l prefix levels (span 2^l).
  // The carry-in is folded into bit 0's generate so gl[4][i] is the carry out of bit i.
  logic [15:0] gl [0:4];
  logic [15:0] pl [0:3];

  assign pl[0] = x ^ y;
  assign gl[0] = {x[15:1] & y[15:1], (x[0] & y[0]) | ((x[0] ^ y[0]) & cin)};

  for (genvar l = 0; l < 4; l++) begin : g_lvl
    for (genvar i = 0; i < 16; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-(1<<l)]);
        if (l < 3) begin : g_p
          assign pl[l+1][i] = pl[l][i] & pl[l][i-(1<<l)];
        end
      end else begin : g_pass
        assign gl[l+1][i] = gl[l][i];
        if (l < 3) begin : g_p
          assign pl[l+1][i] = pl[l][i];
        end
      end
    end
  end

  assign s[0]    = pl[0][0] ^ cin;
  assign s[15:1] = pl[0][15:1] ^ gl[4][14:0];
  assign s[16]   = gl[4][15];
endmodule

module ks_add_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_wide,
  input  logic [NREQ*16-1:0]   req_x,
  input  logic [NREQ*16-1:0]   req_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [16:0]          rsp_sum,
  output logic                 rsp_last
);
  localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);

  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == LAST_IDX) ? 3'd0 : i + 3'd1;
  endfunction

  logic [2:0]      ptr, ptr_n;
  logic [NREQ-1:0] rot;
  logic [3:0]      wrap_sum;
  logic            arb_any;
  logic [2:0]      arb_idx;
  logic [2:0]      sel_idx;
  logic            sel_any;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic            xfer;
  logic [15:0]     op_x, op_y;
  logic            cin;
  logic            last;
  logic [16:0]     sum;

  // Rotate so bit 0 is the requester at ptr; scan downward so the smallest
  // offset from ptr is the one left standing.
  always_comb begin
    rot      = NREQ'({req_valid, req_valid} >> ptr);
    arb_any  = 1'b0;
    arb_idx  = ptr;
    wrap_sum = 4'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        wrap_sum = {1'b0, ptr} + 4'(k);
        if (wrap_sum >= 4'(NREQ)) wrap_sum = wrap_sum - 4'(NREQ);
        arb_any = 1'b1;
        arb_idx = wrap_sum[2:0];
      end
    end
  end

`ifdef KS_ADD_ARBITER_WIDE_EN
  typedef enum logic {ARB, LOCK} state_t;
  state_t     state, state_n;
  logic       carry_q, carry_n;
  logic [2:0] lock_id, lock_n;
  logic       op_wide;

  // While locked the owner keeps the grant even if it drops valid for a cycle.
  assign sel_idx = (state == LOCK) ? lock_id : arb_idx;
  assign sel_any = (state == LOCK) | arb_any;
  assign cin     = (state == LOCK) ? carry_q : 1'b0;
`else
  logic unused_wide;
  assign unused_wide = ^req_wide;
  assign sel_idx = arb_idx;
  assign sel_any = arb_any;
  assign cin     = 1'b0;
`endif

  assign accept = !rsp_valid || rsp_ready;

  always_comb begin
    grant = '0;
    op_x  = 16'd0;
    op_y  = 16'd0;
`ifdef KS_ADD_ARBITER_WIDE_EN
    op_wide = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == 3'(i)) begin
        grant[i] = sel_any;
        op_x     = req_x[16*i +: 16];
        op_y     = req_y[16*i +: 16];
`ifdef KS_ADD_ARBITER_WIDE_EN
        op_wide  = req_wide[i];
`endif
      end
    end
  end

  assign req_ready = rst ? '0 : (grant & {NREQ{accept}});
  assign xfer      = |(req_valid & req_ready);

  ks_add16 u_add (
    .x   (op_x),
    .y   (op_y),
    .cin (cin),
    .s   (sum)
  );

  always_comb begin
    ptr_n = ptr;
    last  = 1'b1;
`ifdef KS_ADD_ARBITER_WIDE_EN
    state_n = state;
    carry_n = carry_q;
    lock_n  = lock_id;
    case (state)
      ARB: begin
        if (xfer) begin
          if (op_wide) begin
            // Low beat: ptr stays put so fairness resumes after the high beat.
            last    = 1'b0;
            carry_n = sum[16];
            lock_n  = sel_idx;
            state_n = LOCK;
          end else begin
            ptr_n = next_idx(sel_idx);
          end
        end
      end
      LOCK: begin
        if (xfer) begin
          ptr_n   = next_idx(lock_id);
          state_n = ARB;
        end
      end
      default: state_n = ARB;
    endcase
`else
    if (xfer) ptr_n = next_idx(sel_idx);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_sum   <= 17'd0;
      rsp_id    <= 3'd0;
      rsp_last  <= 1'b0;
`ifdef KS_ADD_ARBITER_WIDE_EN
      state     <= ARB;
      carry_q   <= 1'b0;
      lock_id   <= 3'd0;
`endif
    end else begin
      ptr <= ptr_n;
`ifdef KS_ADD_ARBITER_WIDE_EN
      state   <= state_n;
      carry_q <= carry_n;
      lock_id <= lock_n;
`endif
      if (xfer) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= sum;
        rsp_id    <= sel_idx;
        rsp_last  <= last;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/ks_add_arbiter.md
KS_ADD_ARBITER -- requirements
Module: ks_add_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one 16-bit Kogge-Stone adder; legal range 2..8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  NREQ  per-requester operation valid.
REQ-005 SHALL have port req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-006 SHALL have port req_wide  input  NREQ  per-requester 32-bit two-beat operation flag, meaningful on the low beat.
REQ-007 SHALL have port req_x  input  NREQ*16  operand X, requester i at bits [16i+15:16i].
REQ-008 SHALL have port req_y  input  NREQ*16  operand Y, same packing.
REQ-009 SHALL have port rsp_valid  output  1  result buffer holds a result.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port rsp_id  output  3  index of the requester owning the result.
REQ-012 SHALL have port rsp_sum  output  17  X+Y+Cin; bit 16 is carry-out.
REQ-013 SHALL have port rsp_last  output  1  high on a single-beat result or the high beat of a wide operation.

Function
REQ-014 SHALL instantiate exactly one 16-bit Kogge-Stone adder (X, Y, Cin -> 17-bit S) shared by all requesters.
REQ-015 SHALL handshake: a beat transfers when req_valid[i] && req_ready[i]; req_ready[i] = grant[i] && (!rsp_valid || rsp_ready).
REQ-016 SHALL have FSM states ARB and LOCK; ARB: grant = first requester with req_valid set, searching upward from pointer ptr with wrap modulo NREQ.
REQ-017 SHALL, in ARB, on transfer with req_wide=0: Cin=0, rsp_last=1, ptr <= grant index+1 mod NREQ, stay ARB.
REQ-018 SHALL, in ARB, on transfer with req_wide=1: Cin=0, rsp_last=0, store carry_q <= S[16], lock_id <= index, go LOCK; ptr unchanged.
REQ-019 SHALL, in LOCK: grant only lock_id regardless of other req_valid; on transfer Cin=carry_q, rsp_last=1, ptr <= lock_id+1 mod NREQ, go ARB.
REQ-020 SHALL register result: beat transferred in cycle n gives rsp_valid=1 with rsp_sum/rsp_id/rsp_last in cycle n+1.
REQ-021 SHALL hold rsp_* stable while rsp_valid && !rsp_ready; simultaneous drain and new transfer in the same cycle loads the new result with no bubble.
REQ-022 SHALL clear rsp_valid the cycle after rsp_ready when no new transfer occurs.
REQ-023 SHALL ignore req_wide in LOCK; high-beat req_x/req_y are the upper operand halves.
REQ-024 SHALL, with no req_valid asserted, drive req_ready all-zero and leave ptr unchanged.
REQ-025 SHALL sustain one beat per cycle when rsp_ready is held high.

Reset
REQ-026 SHALL on rst asynchronously set state=ARB, ptr=0, carry_q=0, lock_id=0, rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_last=0; req_ready=0 while rst is high.
REQ-027 SHALL, if reset asserts in LOCK, abandon the wide operation; no high-beat result is produced.

Configuration
REQ-028 SHALL gate wide support with macro KS_ADD_ARBITER_WIDE_EN.
REQ-029 SHALL, with KS_ADD_ARBITER_WIDE_EN defined, behave per REQ-018, REQ-019 and REQ-023.
REQ-030 SHALL, without KS_ADD_ARBITER_WIDE_EN, ignore req_wide, never enter LOCK, use Cin=0 always, drive rsp_last=1 on every result, and omit carry_q and lock_id.

Verification
REQ-031 SHALL cover single beat: req 2, X=0xFFFF, Y=0x0001 -> next cycle rsp_valid=1, rsp_id=2, rsp_sum=0x10000, rsp_last=1.
REQ-032 SHALL cover round-robin: all four valid continuously with rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-033 SHALL cover wide op (macro on): req 1 low X=0xFFFF, Y=0x0001, then high X=0x0000, Y=0x0000, with req 0 also valid -> low rsp_sum=0x10000, rsp_last=0; high rsp_sum=0x00001, rsp_last=1; req 0 granted only after the high beat.
REQ-034 SHALL cover backpressure: rsp_ready=0 for 3 cycles with a result pending -> req_ready all-zero, rsp_* stable; on rsp_ready=1 a waiting beat transfers the same cycle.
REQ-035 SHALL cover reset in LOCK: rst pulsed after a wide low beat -> rsp_valid=0, ptr=0, next grant follows ARB from requester 0.
REQ-036 SHALL cover macro off: req_wide=1 with X=0x8000, Y=0x8000 -> rsp_sum=0x10000, rsp_last=1, state stays ARB.
